// File: rtl/sm4_decrypt_core.sv
// Iterative SM4 block decryptor: 32 key-expansion cycles, then 32 rounds with reversed round keys.
// Optional build macro KEY_CACHE_EN: reuse the previous key expansion when the same key is presented.

module sm4_decrypt_core #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned WW  = 32;
  localparam int unsigned BW  = 128;
  localparam int unsigned CW  = 5;
  localparam int unsigned NRK = 32;
  localparam logic [BW-1:0] FK   = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KEYEXP = 2'd1,
    S_DEC    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;
  logic [BW-1:0]   r_out_data;
  logic [BW-1:0]   r_k;
  logic [BW-1:0]   r_x;
  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_rk [NRK];

  logic            w_accept;
  logic            w_kexp_en;
  logic            w_dec_en;
  logic            w_last;
  logic            w_hit;
  logic [CW-1:0]   w_rk_idx;
  logic [WW-1:0]   w_k_mix;
  logic [WW-1:0]   w_x_mix;
  logic [WW-1:0]   w_sel;
  logic [WW-1:0]   w_tau;
  logic [WW-1:0]   w_rk_new;
  logic [WW-1:0]   w_x_new;

  function automatic logic [WW-1:0] rotl(input logic [WW-1:0] a, input int unsigned n);
    return (a << n) | (a >> (WW - n));
  endfunction

  function automatic logic [WW-1:0] l_data(input logic [WW-1:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [WW-1:0] l_key(input logic [WW-1:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  // CK byte j of round i is (4i+j)*7 mod 256; 8-bit arithmetic supplies the modulo
  function automatic logic [WW-1:0] ck_word(input logic [CW-1:0] i);
    logic [7:0]    base;
    logic [WW-1:0] w;
    base = {1'b0, i, 2'b00};
    w    = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = 8'((base + 8'(j)) * 8'd7);
    end
    return w;
  endfunction

`ifdef KEY_CACHE_EN
  logic [BW-1:0] r_key_hold;
  logic          r_key_vld;

  assign w_hit = r_key_vld && (in_key == r_key_hold);

  // Held key is invalidated on a miss so an aborted expansion can never be reused
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_hold <= '0;
      r_key_vld  <= 1'b0;
    end else if (w_accept && !w_hit) begin
      r_key_hold <= in_key;
      r_key_vld  <= 1'b0;
    end else if (w_kexp_en && w_last) begin
      r_key_vld  <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Next-state and datapath enables
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_kexp_en = 1'b0;
    w_dec_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
          w_next   = w_hit ? S_DEC : S_KEYEXP;
        end
      end
      S_KEYEXP: begin
        w_kexp_en = 1'b1;
        if (w_last) w_next = S_DEC;
      end
      S_DEC: begin
        w_dec_en = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_busy      <= (w_next == S_KEYEXP) || (w_next == S_DEC);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  assign w_last   = (r_cnt == LAST);
  assign w_rk_idx = LAST - r_cnt;
  assign w_k_mix  = r_k[95:64] ^ r_k[63:32] ^ r_k[31:0] ^ ck_word(r_cnt);
  assign w_x_mix  = r_x[95:64] ^ r_x[63:32] ^ r_x[31:0] ^ r_rk[w_rk_idx];
  assign w_sel    = (r_state == S_DEC) ? w_x_mix : w_k_mix;

  // Four byte S-boxes shared by key expansion and data rounds
  for (genvar g = 0; g < 4; g++) begin : g_tau
    sbox u_sbox (
      .i_a   (w_sel[8*g +: 8]),
      .o_y_c (w_tau[8*g +: 8])
    );
  end

  assign w_rk_new = r_k[127:96] ^ l_key(w_tau);
  assign w_x_new  = r_x[127:96] ^ l_data(w_tau);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= '0;
      r_x        <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      for (int i = 0; i < int'(NRK); i++) begin
        r_rk[i] <= '0;
      end
    end else if (w_accept) begin
      r_k   <= in_key ^ FK;
      r_x   <= in_data;
      r_cnt <= '0;
    end else if (w_kexp_en) begin
      r_rk[r_cnt] <= w_rk_new;
      r_k         <= {r_k[95:0], w_rk_new};
      r_cnt       <= w_last ? '0 : r_cnt + CW'(1);
    end else if (w_dec_en) begin
      r_x   <= {r_x[95:0], w_x_new};
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      // Final state words come out in reverse order: X35, X34, X33, X32
      if (w_last) r_out_data <= {w_x_new, r_x[31:0], r_x[63:32], r_x[95:64]};
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// SM4 byte substitution table lookup (purely combinational).
module sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y_c
);

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign o_y_c = SBOX_TBL[i_a];

endmodule

// File: tb/tb_sm4_decrypt_core.sv
// Self-checking bench for sm4_decrypt_core: random blocks are encrypted by a word-level
// SM4 model here and the core must recover the plaintext with the expected timing.

module tb_sm4_decrypt_core;

  localparam logic [127:0] STD_KEY  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT   = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] FK_ALL   = 128'ha3b1bac656aa3350677d9197b27022dc;
  localparam int           LAT_FULL = 65;
  localparam int           LAT_HIT  = 33;
`ifdef KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int           cyc;
  int           n_checks;
  int           n_fail;
  logic [127:0] m_key;
  bit           m_vld;

  sm4_decrypt_core #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = SB[a[8*j +: 8]];
    return r;
  endfunction

  // Reference SM4 encryption over the full word sequences K0..K35 and X0..X35
  function automatic logic [127:0] sm4_encrypt(input logic [127:0] mk, input logic [127:0] pt);
    logic [31:0]  k [36];
    logic [31:0]  x [36];
    logic [127:0] kf;
    logic [31:0]  ck;
    logic [31:0]  b;
    kf = mk ^ FK_ALL;
    for (int i = 0; i < 4; i++) begin
      k[i] = kf[127-32*i -: 32];
      x[i] = pt[127-32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      b      = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
    end
    for (int i = 0; i < 32; i++) begin
      b      = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // Expected accept-to-output latency, tracking the key cache when it is built
  function automatic int note_accept(input logic [127:0] k);
    int lat;
    lat   = (CACHE && m_vld && (k == m_key)) ? LAT_HIT : LAT_FULL;
    m_key = k;
    m_vld = 1'b1;
    return lat;
  endfunction

  // Present one block from IDLE, return plaintext and latency in cycles; consumes the result
  task automatic do_block(input logic [127:0] k, input logic [127:0] d,
                          output logic [127:0] got, output int lat, output bit to);
    int acc;
    int n;
    to        = 1'b0;
    in_key    = k;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc       = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_key   = rnd128();
    in_data  = rnd128();
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) to = 1'b1;
    lat = cyc - acc;
    got = out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_key    = '0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst   = 1'b0;
    m_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_standard();
    logic [127:0] got;
    int lat, le;
    bit to;
    le = note_accept(STD_KEY);
    do_block(STD_KEY, STD_CT, got, lat, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL std_timeout: out_valid never rose"); end
    n_checks++;
    if (got !== STD_KEY) begin n_fail++; $display("FAIL std_plaintext: got %h want %h", got, STD_KEY); end
    n_checks++;
    if (lat != le) begin n_fail++; $display("FAIL std_latency: got %0d want %0d", lat, le); end
  endtask

  task automatic test_random();
    logic [127:0] k, pt, ct, got;
    int lat, le;
    bit to;
    k = rnd128();
    for (int i = 0; i < 6; i++) begin
      if (i != 3) k = rnd128();
      pt = rnd128();
      ct = sm4_encrypt(k, pt);
      le = note_accept(k);
      do_block(k, ct, got, lat, to);
      n_checks++;
      if (got !== pt) begin n_fail++; $display("FAIL rand_plaintext[%0d]: got %h want %h", i, got, pt); end
      n_checks++;
      if (lat != le) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, le); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    void'(note_accept(STD_KEY));
    in_key   = STD_KEY;
    in_data  = STD_CT;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_done: got %b want 0", busy); end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom % 2);
      in_key   = rnd128();
      in_data  = rnd128();
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, out_valid); end
      n_checks++;
      if (out_data !== STD_KEY) begin n_fail++; $display("FAIL bp_data_stable[%0d]: got %h want %h", i, out_data, STD_KEY); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    logic [127:0] got [3];
    int ac [3];
    int oc [3];
    int le [3];
    int na, no, n;
    k = rnd128();
    for (int b = 0; b < 3; b++) begin
      pt[b]  = rnd128();
      ct[b]  = sm4_encrypt(k, pt[b]);
      got[b] = 'x;
      ac[b]  = 0;
      oc[b]  = 0;
      le[b]  = 0;
    end
    na = 0; no = 0; n = 0;
    out_ready = 1'b1;
    while (no < 3 && n < 600) begin
      if (out_valid) begin
        got[no] = out_data;
        oc[no]  = cyc;
        no++;
      end
      in_valid = (na < 3);
      if (na < 3) begin
        in_key  = k;
        in_data = ct[na];
        if (in_ready) begin
          ac[na] = cyc;
          le[na] = note_accept(k);
          na++;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (no != 3) begin n_fail++; $display("FAIL b2b_count: got %0d outputs want 3", no); end
    for (int b = 0; b < 3; b++) begin
      n_checks++;
      if (got[b] !== pt[b]) begin n_fail++; $display("FAIL b2b_plaintext[%0d]: got %h want %h", b, got[b], pt[b]); end
      n_checks++;
      if (oc[b] - ac[b] != le[b]) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", b, oc[b] - ac[b], le[b]); end
    end
    for (int b = 1; b < 3; b++) begin
      n_checks++;
      if (ac[b] - ac[b-1] != le[b-1] + 1) begin
        n_fail++; $display("FAIL b2b_accept_gap[%0d]: got %0d want %0d", b, ac[b] - ac[b-1], le[b-1] + 1);
      end
    end
  endtask

  task automatic test_busy_stability();
    logic [127:0] k, pt, ct;
    int acc, le, n;
    k  = rnd128();
    pt = rnd128();
    ct = sm4_encrypt(k, pt);
    le = note_accept(k);
    out_ready = 1'b1;
    in_key    = k;
    in_data   = ct;
    in_valid  = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL stab_busy[%0d]: got %b want 1", i, busy); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stab_in_ready[%0d]: got %b want 0", i, in_ready); end
      in_valid = 1'($urandom % 2);
      in_key   = rnd128();
      in_data  = rnd128();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (out_data !== pt || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stab_plaintext: got %h valid %b want %h", out_data, out_valid, pt);
    end
    n_checks++;
    if (cyc - acc != le) begin n_fail++; $display("FAIL stab_latency: got %0d want %0d", cyc - acc, le); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, pt, ct, got;
    int lat, le;
    bit to;
    k  = rnd128();
    pt = rnd128();
    ct = sm4_encrypt(k, pt);
    void'(note_accept(k));
    out_ready = 1'b1;
    in_key    = k;
    in_data   = ct;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (42) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    m_vld = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++;
    if (out_data !== 128'h0) begin n_fail++; $display("FAIL mid_out_data: got %h want 0", out_data); end
    le = note_accept(STD_KEY);
    do_block(STD_KEY, STD_CT, got, lat, to);
    n_checks++;
    if (got !== STD_KEY) begin n_fail++; $display("FAIL mid_std_plaintext: got %h want %h", got, STD_KEY); end
    n_checks++;
    if (lat != le) begin n_fail++; $display("FAIL mid_std_latency: got %0d want %0d", lat, le); end
  endtask

  task automatic test_key_cache();
    logic [127:0] k [3];
    logic [127:0] pt, ct, got;
    int lat, le;
    bit to;
    k[0] = rnd128();
    k[1] = k[0];
    k[2] = rnd128();
    for (int i = 0; i < 3; i++) begin
      pt = rnd128();
      ct = sm4_encrypt(k[i], pt);
      le = note_accept(k[i]);
      do_block(k[i], ct, got, lat, to);
      n_checks++;
      if (got !== pt) begin n_fail++; $display("FAIL cache_plaintext[%0d]: got %h want %h", i, got, pt); end
      n_checks++;
      if (lat != le) begin n_fail++; $display("FAIL cache_latency[%0d]: got %0d want %0d", i, lat, le); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_vld    = 1'b0;
    m_key    = '0;
    test_reset();
    test_standard();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_busy_stability();
    test_reset_mid();
    test_key_cache();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
